// File: rtl/wormhole_rr_allocator.sv
// Per-output-port wormhole allocator: round-robin grant among head flits, then the
// output stays locked to the winner until its tail flit or the flit-count watchdog fires.
module wormhole_rr_allocator #(
  parameter int N_IN          = 2,
  parameter int LOG_N_IN      = 1,
  parameter int MAX_PKT_FLITS = 16,
  parameter int LOG_MAX_PKT   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_IN-1:0]     req_in,
  input  logic [N_IN-1:0]     head_in,
  input  logic [N_IN-1:0]     tail_in,
  input  logic                busy_in,
  output logic [LOG_N_IN-1:0] select,
  output logic                valid_out,
  output logic [N_IN-1:0]     pop_out,
  output logic                locked,
  output logic [1:0]          err
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]             state;
  logic [LOG_N_IN-1:0]    owner;
  logic [LOG_N_IN-1:0]    ptr;
  logic [LOG_MAX_PKT-1:0] cnt;

  logic [N_IN-1:0]        eligible;
  logic [N_IN-1:0]        owner_mask;
  logic [LOG_N_IN-1:0]    winner;
  logic                   any_elig;
  logic                   xfer;
  logic                   xfer_tail;
  logic                   orphan;
  logic                   wd_hit;

  // Explicit wrap so non-power-of-two N_IN never indexes a missing input.
  function automatic logic [LOG_N_IN-1:0] wrap_inc(input logic [LOG_N_IN-1:0] v);
    if (int'(v) >= N_IN - 1) return '0;
    return v + LOG_N_IN'(1);
  endfunction

  always_comb begin
    eligible = req_in & head_in;
    any_elig = 1'b0;
    winner   = ptr;
    for (int k = 0; k < N_IN; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= N_IN) idx = idx - N_IN;
      if (!any_elig && eligible[idx]) begin
        any_elig = 1'b1;
        winner   = LOG_N_IN'(idx);
      end
    end

    owner_mask = N_IN'(1) << owner;
    if (state == IDLE) begin
      xfer      = any_elig & ~busy_in;
      xfer_tail = tail_in[winner];
      select    = xfer ? winner : ptr;
      orphan    = |(req_in & ~head_in);
    end else begin
      xfer      = req_in[owner] & ~busy_in;
      xfer_tail = tail_in[owner];
      select    = owner;
      orphan    = |(req_in & ~head_in & ~owner_mask);
    end

    // Count including the flit moving now; a tail on this same flit wins over the watchdog.
    wd_hit    = (int'(cnt) + 1) >= MAX_PKT_FLITS;
    valid_out = xfer;
    pop_out   = xfer ? (N_IN'(1) << select) : '0;
  end

  assign locked = (state == LOCKED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
      err   <= '0;
    end else begin
      if (orphan) err[1] <= 1'b1;
      if (xfer) begin
        if (state == IDLE) begin
          if (xfer_tail) begin
            ptr <= wrap_inc(winner);
          end else begin
            state <= LOCKED;
            owner <= winner;
            cnt   <= LOG_MAX_PKT'(1);
          end
        end else if (xfer_tail || wd_hit) begin
          state <= IDLE;
          ptr   <= wrap_inc(owner);
          cnt   <= '0;
          if (!xfer_tail) err[0] <= 1'b1;
        end else begin
          cnt <= cnt + LOG_MAX_PKT'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_wormhole_rr_allocator.sv
// Bench for wormhole_rr_allocator: per-input flit sources, a packet-level reference
// model predicting each cycle's grant, and a scoreboard monitor comparing DUT output.
module tb_wormhole_rr_allocator;

  localparam int NI  = 3;
  localparam int LNI = 2;
  localparam int MAXF = 4;
  localparam int LMX = 3;

  logic           clk;
  logic           rst;
  logic [NI-1:0]  req_in, head_in, tail_in;
  logic           busy_in;
  logic [LNI-1:0] select;
  logic           valid_out;
  logic [NI-1:0]  pop_out;
  logic           locked;
  logic [1:0]     err;

  wormhole_rr_allocator #(
    .N_IN(NI), .LOG_N_IN(LNI), .MAX_PKT_FLITS(MAXF), .LOG_MAX_PKT(LMX)
  ) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .head_in(head_in), .tail_in(tail_in),
    .busy_in(busy_in), .select(select), .valid_out(valid_out), .pop_out(pop_out),
    .locked(locked), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Flit sources: ring buffer per input of {head, tail} codes.
  logic [1:0] fbuf [NI][64];
  int         rd   [NI];
  int         fill [NI];

  task automatic push_pkt(input int i, input int len);
    for (int k = 0; k < len; k++) begin
      fbuf[i][(rd[i] + fill[i]) % 64] = {k == 0, k == len - 1};
      fill[i]++;
    end
  endtask

  task automatic clear_src();
    for (int i = 0; i < NI; i++) begin
      rd[i] = 0;
      fill[i] = 0;
    end
  endtask

  // Reference model: packet-level view of who owns the output.
  bit          m_lk;
  int          m_owner, m_ptr, m_cnt;
  logic [1:0]  m_err;
  bit          n_lk;
  int          n_owner, n_ptr, n_cnt;
  logic [1:0]  n_err;

  logic           exp_valid, exp_locked;
  logic [LNI-1:0] exp_sel;
  logic [1:0]     exp_err;
  logic [NI+LNI-1:0] sb_q[$];
  int exp_total = 0;

  task automatic model_reset();
    m_lk = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_err = 2'b00;
  endtask

  task automatic model_eval(input logic [NI-1:0] r, input logic [NI-1:0] h,
                            input logic [NI-1:0] t, input logic b, output logic [NI-1:0] p);
    int win;
    bit orph;
    n_lk = m_lk; n_owner = m_owner; n_ptr = m_ptr; n_cnt = m_cnt; n_err = m_err;
    p = '0;
    orph = 0;
    exp_valid = 0;
    if (!m_lk) begin
      win = -1;
      for (int k = NI - 1; k >= 0; k--)
        if (r[(m_ptr + k) % NI] && h[(m_ptr + k) % NI]) win = (m_ptr + k) % NI;
      for (int i = 0; i < NI; i++) if (r[i] && !h[i]) orph = 1;
      exp_sel = LNI'(m_ptr);
      if (win >= 0 && !b) begin
        exp_valid = 1;
        exp_sel = LNI'(win);
        p[win] = 1'b1;
        if (t[win]) n_ptr = (win + 1) % NI;
        else begin n_lk = 1; n_owner = win; n_cnt = 1; end
      end
    end else begin
      for (int i = 0; i < NI; i++) if (i != m_owner && r[i] && !h[i]) orph = 1;
      exp_sel = LNI'(m_owner);
      if (r[m_owner] && !b) begin
        exp_valid = 1;
        p[m_owner] = 1'b1;
        n_cnt = m_cnt + 1;
        if (t[m_owner] || n_cnt == MAXF) begin
          if (!t[m_owner]) n_err[0] = 1'b1;
          n_lk = 0; n_ptr = (m_owner + 1) % NI; n_cnt = 0;
        end
      end
    end
    if (orph) n_err[1] = 1'b1;
    exp_locked = m_lk;
    exp_err = m_err;
  endtask

  // One cycle: present source fronts, predict, advance on the edge.
  task automatic step(input logic [NI-1:0] gate, input logic b);
    logic [NI-1:0] r, h, t, p;
    for (int i = 0; i < NI; i++) begin
      r[i] = (fill[i] > 0) && gate[i];
      h[i] = r[i] ? fbuf[i][rd[i]][1] : 1'b0;
      t[i] = r[i] ? fbuf[i][rd[i]][0] : 1'b0;
    end
    req_in = r; head_in = h; tail_in = t; busy_in = b;
    model_eval(r, h, t, b, p);
    if (exp_valid) begin
      sb_q.push_back({p, exp_sel});
      exp_total++;
    end
    for (int i = 0; i < NI; i++) if (p[i]) begin
      rd[i] = (rd[i] + 1) % 64;
      fill[i]--;
    end
    @(posedge clk);
    m_lk = n_lk; m_owner = n_owner; m_ptr = n_ptr; m_cnt = n_cnt; m_err = n_err;
    #1;
  endtask

  task automatic do_reset();
    req_in = '0; head_in = '0; tail_in = '0; busy_in = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_pop", 32'(pop_out), 0);
    chk("rst_select", 32'(select), 0);
    model_reset();
    clear_src();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Monitor: compare DUT against the scoreboard away from the active edge.
  int n_valid = 0;
  int pop_cnt [NI];

  initial begin
    logic [NI+LNI-1:0] e;
    for (int i = 0; i < NI; i++) pop_cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("locked", 32'(locked), 32'(exp_locked));
        chk("err", 32'(err), 32'(exp_err));
        chk("valid", 32'(valid_out), 32'(exp_valid));
        if (valid_out) begin
          n_valid++;
          for (int i = 0; i < NI; i++) if (pop_out[i]) pop_cnt[i]++;
          if (sb_q.size() == 0) begin
            chk("sb_has_entry", 0, 1);
          end else begin
            e = sb_q.pop_front();
            chk("pop", 32'(pop_out), 32'(e[NI+LNI-1:LNI]));
            chk("select", 32'(select), 32'(e[LNI-1:0]));
          end
        end else begin
          if (exp_valid && sb_q.size() > 0) void'(sb_q.pop_front());
          chk("pop_idle", 32'(pop_out), 0);
          chk("select_idle", 32'(select), 32'(exp_sel));
        end
      end
    end
  end

  initial begin
    int v0, p0;
    rst = 1'b0;
    req_in = '0; head_in = '0; tail_in = '0; busy_in = 1'b0;
    exp_valid = 0; exp_locked = 0; exp_sel = '0; exp_err = '0;
    model_reset();
    clear_src();
    do_reset();

    // 3-flit packet on input 0
    v0 = n_valid;
    push_pkt(0, 3);
    for (int c = 0; c < 5; c++) step('1, 1'b0);
    chk("t1_valid_cnt", 32'(n_valid - v0), 3);

    // single-flit packets on inputs 0 and 1 from reset: alternate grants
    do_reset();
    for (int k = 0; k < 4; k++) begin push_pkt(0, 1); push_pkt(1, 1); end
    v0 = n_valid;
    for (int c = 0; c < 8; c++) step('1, 1'b0);
    chk("t2_valid_cnt", 32'(n_valid - v0), 8);

    // input 1 head waits behind input 0's 4-flit packet (tail at watchdog limit)
    push_pkt(0, 4);
    push_pkt(1, 1);
    p0 = pop_cnt[1];
    step(3'b001, 1'b0);
    for (int c = 0; c < 3; c++) step(3'b011, 1'b0);
    chk("t3_in1_wait", 32'(pop_cnt[1] - p0), 0);
    step(3'b011, 1'b0);
    chk("t3_in1_pop", 32'(pop_cnt[1] - p0), 1);
    chk("t3_err", 32'(err), 0);

    // busy pulse mid-packet
    push_pkt(0, 4);
    v0 = n_valid;
    step('1, 1'b0); step('1, 1'b0); step('1, 1'b1); step('1, 1'b1);
    for (int c = 0; c < 4; c++) step('1, 1'b0);
    chk("t4_valid_cnt", 32'(n_valid - v0), 4);

    // reset while locked drops the lock immediately
    push_pkt(2, 4);
    step('1, 1'b0); step('1, 1'b0);
    chk("t6_locked_before", 32'(locked), 1);
    do_reset();

    // 6-flit packet on input 1 trips the watchdog, remnants become orphans
    push_pkt(1, 6);
    p0 = pop_cnt[1];
    for (int c = 0; c < 7; c++) step('1, 1'b0);
    chk("t5_err", 32'(err), 3);
    chk("t5_in1_pops", 32'(pop_cnt[1] - p0), 4);
    do_reset();

    // randomized traffic with bubbles and busy
    v0 = n_valid;
    p0 = exp_total;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NI; i++) if (fill[i] < 6) push_pkt(i, $urandom_range(1, MAXF));
      step(NI'($urandom_range(0, 7)), $urandom_range(0, 3) == 0);
    end
    chk("rand_valid_cnt", 32'(n_valid - v0), 32'(exp_total - p0));
    chk("sb_drained", 32'(sb_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
